// File: rtl/watch_pkg.sv
// Shared types and helpers for the watch front end: key FSM state encoding
// and millisecond-to-cycle conversion used to size debounce and hold timers.
package watch_pkg;

  localparam int unsigned IN_CLK_HZ_DEFAULT = 50_000_000;

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    PRESSED,
    LONG,
    DB_RELEASE
  } key_state_t;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One push-button channel: two-flop synchroniser, press/release debounce and
// short/long press classification with registered pulse and level outputs.
module key_channel
  import watch_pkg::*;
#(
  parameter int unsigned DB_CYC     = 4,
  parameter int unsigned LONG_CYC   = 20,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_first,
  output logic key_long,
  output logic key_short
);

  localparam int DB_W   = $clog2(DB_CYC);
  localparam int LONG_W = $clog2(LONG_CYC);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC - 1);

  if (DB_CYC < 2 || LONG_CYC <= DB_CYC) begin : g_bad_params
    $error("key_channel: need DB_CYC >= 2 and LONG_CYC > DB_CYC");
  end

  logic sync_q1;
  logic sync_q2;
  logic act;

  // NOTE: every clocked block uses non-blocking assignments so all flops
  // sample the same pre-edge values; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= ACTIVE_LOW;
      sync_q2 <= ACTIVE_LOW;
    end else begin
      sync_q1 <= key_raw;
      sync_q2 <= sync_q1;
    end
  end

  assign act = sync_q2 ^ ACTIVE_LOW;

  key_state_t          state;
  logic [DB_W-1:0]     db_cnt;
  logic [LONG_W-1:0]   hold_cnt;
  logic                from_long;

  // Counters only advance below their terminal value, so they never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      db_cnt    <= '0;
      hold_cnt  <= '0;
      from_long <= 1'b0;
      key_first <= 1'b0;
      key_long  <= 1'b0;
      key_short <= 1'b0;
    end else begin
      key_first <= 1'b0;
      key_short <= 1'b0;
      case (state)
        IDLE: begin
          if (act) begin
            state  <= DB_PRESS;
            db_cnt <= '0;
          end
        end
        DB_PRESS: begin
          if (!act) begin
            state <= IDLE;
          end else if (db_cnt == DB_LAST) begin
            state     <= PRESSED;
            hold_cnt  <= '0;
            key_first <= 1'b1;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        PRESSED: begin
          if (!act) begin
            state     <= DB_RELEASE;
            db_cnt    <= '0;
            from_long <= 1'b0;
          end else if (hold_cnt == LONG_LAST) begin
            state    <= LONG;
            key_long <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + LONG_W'(1);
          end
        end
        LONG: begin
          if (!act) begin
            state     <= DB_RELEASE;
            db_cnt    <= '0;
            from_long <= 1'b1;
          end
        end
        DB_RELEASE: begin
          // A bounce back to pressed resumes the hold timer where it stopped.
          if (act) begin
            state <= from_long ? LONG : PRESSED;
          end else if (db_cnt == DB_LAST) begin
            state     <= IDLE;
            key_long  <= 1'b0;
            key_short <= ~from_long;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          key_long <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_press_detect.sv
// Multi-key front end: one independent debounce/classify channel per button,
// producing press pulses, hold levels and short-release pulses for the watch.
module key_press_detect
  import watch_pkg::*;
#(
  parameter int unsigned NUM_KEYS       = 2,
  parameter int unsigned IN_CLK_HZ      = IN_CLK_HZ_DEFAULT,
  parameter int unsigned DEBOUNCE_MS    = 20,
  parameter int unsigned LONG_MS        = 1000,
  parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_first,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_short
);

  localparam int unsigned DB_CYC   = ms_to_cycles(IN_CLK_HZ, DEBOUNCE_MS);
  localparam int unsigned LONG_CYC = ms_to_cycles(IN_CLK_HZ, LONG_MS);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_channel #(
      .DB_CYC    (DB_CYC),
      .LONG_CYC  (LONG_CYC),
      .ACTIVE_LOW(KEY_ACTIVE_LOW)
    ) u_channel (
      .clk      (clk),
      .rst_n    (rst_n),
      .key_raw  (key_raw[i]),
      .key_first(key_first[i]),
      .key_long (key_long[i]),
      .key_short(key_short[i])
    );
  end

endmodule
